// File: rtl/flopoco_11_14_pkg.sv
// Shared definitions for the FloPoCo 11_14 word: field widths, exponent bias,
// exception codes and the fixed-to-float encoder state type.
package flopoco_11_14_pkg;

    localparam int WE   = 11;
    localparam int WF   = 14;
    localparam int FP_W = 28;
    localparam int BIAS = 1023;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/fp_round_14.sv
// Mantissa rounding for the 14-bit FloPoCo fraction.
// FP_ENC_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_round_14
    import flopoco_11_14_pkg::*;
(
    input  logic [WF-1:0] mant,
    input  logic          guard,
    input  logic          sticky,
    output logic [WF-1:0] mant_rnd,
    output logic          carry
);

`ifdef FP_ENC_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    function automatic logic round_up(input logic g, input logic s, input logic lsb);
        return RNE & g & (s | lsb);
    endfunction

    logic inc;

    always_comb begin
        inc               = round_up(guard, sticky, mant[0]);
        {carry, mant_rnd} = {1'b0, mant} + {{WF{1'b0}}, inc};
    end

endmodule

// File: rtl/fix_to_flopoco_11_14.sv
// Sequential signed fixed-point to FloPoCo 11_14 encoder, one normalising shift per cycle.
// Build option: FP_ENC_RNE_EN enables round-to-nearest-even (truncation otherwise).
module fix_to_flopoco_11_14
    import flopoco_11_14_pkg::*;
#(
    parameter int IN_W = 32,
    parameter int FRAC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [FP_W-1:0]        out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int SH_W  = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int EXT_W = IN_W + WF;
    localparam logic [WE-1:0] EXP_TOP = WE'(BIAS + IN_W - 1 - FRAC);

    enc_state_e      state, state_nxt;
    logic [IN_W-1:0] mag, mag_nxt;
    logic [SH_W-1:0] sh, sh_nxt;
    logic            sign, sign_nxt;
    logic [FP_W-1:0] out_data_nxt;

    logic [IN_W-1:0]  in_mag;
    logic [EXT_W-1:0] ext;
    logic [WF-1:0]    mant, mant_rnd;
    logic             guard, sticky, rnd_carry;
    logic [WE-1:0]    exp_base, exp_fin;

    // Two's-complement magnitude; the most negative input maps to 2^(IN_W-1) unchanged.
    assign in_mag = in_data[IN_W-1] ? $unsigned(-in_data) : $unsigned(in_data);

    // Once normalised, mag's MSB is the hidden one; everything below feeds the fraction.
    assign ext    = {mag[IN_W-2:0], {(WF+1){1'b0}}};
    assign mant   = ext[EXT_W-1 -: WF];
    assign guard  = ext[EXT_W-1-WF];
    assign sticky = |ext[EXT_W-2-WF:0];

    assign exp_base = EXP_TOP - WE'(sh);
    assign exp_fin  = exp_base + {{(WE-1){1'b0}}, rnd_carry};

    fp_round_14 u_round (
        .mant     (mant),
        .guard    (guard),
        .sticky   (sticky),
        .mant_rnd (mant_rnd),
        .carry    (rnd_carry)
    );

    always_comb begin
        state_nxt    = state;
        mag_nxt      = mag;
        sh_nxt       = sh;
        sign_nxt     = sign;
        out_data_nxt = out_data;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_nxt = in_data[IN_W-1];
                    mag_nxt  = in_mag;
                    if (in_mag == '0) begin
                        out_data_nxt = '0;
                        state_nxt    = DONE;
                    end else begin
                        sh_nxt    = '0;
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[IN_W-1]) begin
                    state_nxt = ROUND;
                end else begin
                    mag_nxt = mag << 1;
                    sh_nxt  = sh + SH_W'(1);
                end
            end
            ROUND: begin
                out_data_nxt = {EXC_NORMAL, sign, exp_fin, mant_rnd};
                state_nxt    = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and visible outputs: reset to idle, nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_data  <= out_data_nxt;
            out_valid <= (state_nxt == DONE);
            in_ready  <= (state_nxt == IDLE);
        end
    end

    // Working operand registers are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        mag  <= mag_nxt;
        sh   <= sh_nxt;
        sign <= sign_nxt;
    end

endmodule

// File: tb/tb_fix_to_flopoco_11_14.sv
// Directed bench for fix_to_flopoco_11_14 (IN_W=32, FRAC=16) with an arithmetic reference model.
module tb_fix_to_flopoco_11_14;

    localparam int IN_W = 32;
    localparam int FRAC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [31:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic [27:0]       out_data;
    logic              out_valid;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [27:0] exp_word = '0;
    logic        exp_vld = 1'b0;

    fix_to_flopoco_11_14 #(.IN_W(IN_W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int msb_pos(input longint m);
        int p = 0;
        for (int i = 0; i < 33; i++)
            if (m >= (longint'(1) << i)) p = i;
        return p;
    endfunction

    // value = d / 2^16 = (1 + q/2^14) * 2^(p-16); q = floor(rem * 2^14 / 2^p), r the remainder.
    function automatic logic [27:0] model_word(input logic [31:0] d);
        longint v, mag, rem, num, q, r, one_p;
        int     p, e;
        v   = longint'($signed(d));
        mag = (v < 0) ? -v : v;
        if (mag == 0) return 28'h0;
        p     = msb_pos(mag);
        one_p = longint'(1) << p;
        e     = 1023 + p - FRAC;
        rem   = mag - one_p;
        num   = rem << 14;
        q     = num >> p;
        r     = num - (q << p);
`ifdef FP_ENC_RNE_EN
        if ((2 * r > one_p) || ((2 * r == one_p) && (q % 2 == 1))) q = q + 1;
`endif
        if (q == 16384) begin
            q = 0;
            e = e + 1;
        end
        return {2'b01, d[31], 11'(e), 14'(q)};
    endfunction

    function automatic int model_lat(input logic [31:0] d);
        longint v, mag;
        v   = longint'($signed(d));
        mag = (v < 0) ? -v : v;
        if (mag == 0) return 1;
        return (31 - msb_pos(mag)) + 2;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && exp_vld)
            check("out_data", out_data, exp_word);
    end

    task automatic send(input logic [31:0] d, input int hold);
        int lat = 0;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        exp_word = model_word(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_vld  = 1'b1;
        check("in_ready_busy", in_ready, 0);
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, model_lat(d));
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_vld   = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Hand-computed anchors for the reference model.
        check("model_1p0",   model_word(32'h00010000), 28'h4FFC000);
        check("model_m1p0",  model_word(32'hFFFF0000), 28'h6FFC000);
        check("model_minneg", model_word(32'h80000000), 28'h7038000);
        check("model_zero",  model_word(32'h00000000), 28'h0000000);
        check("model_lat1p0", model_lat(32'h00010000), 17);
        check("model_latmin", model_lat(32'h80000000), 2);
`ifdef FP_ENC_RNE_EN
        check("model_carry", model_word(32'h0001FFFF), 28'h5000000);
        check("model_tie_even", model_word(32'h00010002), 28'h4FFC000);
        check("model_tie_up", model_word(32'h00010006), 28'h4FFC002);
`else
        check("model_trunc", model_word(32'h0001FFFF), 28'h4FFFFFF);
`endif

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'h00010000, 5);
        send(32'hFFFF0000, 0);
        send(32'h80000000, 0);
        send(32'h00000000, 0);
        send(32'h0001FFFF, 0);
        send(32'h00010002, 0);
        send(32'h00010006, 2);
        send(32'h00000001, 0);
        send(32'h7FFFFFFF, 0);
        send(32'hFFFFFFFF, 0);
        send(32'h00123456, 0);

        // Abort an operand mid-normalisation.
        @(negedge clk);
        in_data  = 32'h00000100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_quiet", out_valid, 0);
        send(32'h00030000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
